mem_bus_ctrl: RTL and testbench

//  Parametrised memory-bus controller between CPU FSM (mem_cmd/mem_addr) and
//  on-chip RAM plus a memory-mapped I/O window. Replaces combinational read/write

---
 rtl/mem_bus_ctrl.sv | 109 ++++++++++
 tb/tb_mem_bus_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: turns CPU mem_cmd/mem_addr requests into single-cycle RAM or
// I/O strobes, waits out the RAM read latency, and answers with a one-cycle mem_ready.
module mem_bus_ctrl #(
   parameter int AW     = 9,
   parameter int DW     = 16,
   parameter int RD_LAT = 1,
   parameter int IO_AW  = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       mem_cmd,
   input  logic [AW-1:0]    mem_addr,
   input  logic [DW-1:0]    wdata,
   output logic             mem_ready,
   output logic [DW-1:0]    rdata,
   output logic             bus_err,
   output logic [AW-2:0]    ram_addr,
   output logic [DW-1:0]    ram_wdata,
   output logic             ram_we,
   output logic             ram_re,
   input  logic [DW-1:0]    ram_rdata,
   output logic [IO_AW-1:0] io_addr,
   output logic [DW-1:0]    io_wdata,
   output logic             io_we,
   output logic             io_re,
   input  logic [DW-1:0]    io_rdata
);

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_WRITE = 2'b01;
   localparam logic [1:0] CMD_READ  = 2'b10;
   localparam logic [1:0] CMD_ILL   = 2'b11;
   localparam logic [3:0] LAT       = 4'(RD_LAT);

   typedef enum logic [1:0] {IDLE, RAM_RD, DONE} state_t;

   state_t          state;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [1:0]      cmd_q;
   logic [3:0]      wait_cnt;

   assign ram_addr  = addr_q[AW-2:0];
   assign io_addr   = addr_q[IO_AW-1:0];
   assign ram_wdata = wdata_q;
   assign io_wdata  = wdata_q;

   // Strobes, ready and error are pulses: cleared every cycle unless this edge raises them.
   // IDLE refuses to capture while mem_ready is high so a held command is not re-taken
   // in the ready cycle itself.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         cmd_q     <= CMD_NONE;
         wait_cnt  <= '0;
         rdata     <= '0;
         mem_ready <= 1'b0;
         bus_err   <= 1'b0;
         ram_we    <= 1'b0;
         ram_re    <= 1'b0;
         io_we     <= 1'b0;
         io_re     <= 1'b0;
      end else begin
         mem_ready <= 1'b0;
         bus_err   <= 1'b0;
         ram_we    <= 1'b0;
         ram_re    <= 1'b0;
         io_we     <= 1'b0;
         io_re     <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_cmd != CMD_NONE && !mem_ready) begin
                  addr_q  <= mem_addr;
                  wdata_q <= wdata;
                  cmd_q   <= mem_cmd;
                  state   <= DONE;
                  if (mem_cmd == CMD_WRITE) begin
                     if (mem_addr[AW-1]) io_we  <= 1'b1;
                     else                ram_we <= 1'b1;
                  end else if (mem_cmd == CMD_READ) begin
                     if (mem_addr[AW-1]) begin
                        io_re <= 1'b1;
                     end else begin
                        ram_re   <= 1'b1;
                        wait_cnt <= LAT;
                        state    <= RAM_RD;
                     end
                  end
               end
            end
            // Leaves one cycle before the count would reach zero; DONE is that final cycle.
            RAM_RD: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) state <= DONE;
            end
            DONE: begin
               mem_ready <= 1'b1;
               bus_err   <= (cmd_q == CMD_ILL);
               if (cmd_q == CMD_READ) rdata <= addr_q[AW-1] ? io_rdata : ram_rdata;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized bench for mem_bus_ctrl: a transaction-level model schedules the expected
// per-cycle outputs, and a compare process checks every cycle against that schedule.
module tb_mem_bus_ctrl;

   localparam int AW = 9, DW = 16, RD_LAT = 3, IO_AW = 4, MAXC = 4096;

   logic              clk, reset_n;
   logic [1:0]        mem_cmd;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     wdata, ram_rdata, io_rdata;
   logic              mem_ready, bus_err, ram_we, ram_re, io_we, io_re;
   logic [DW-1:0]     rdata, ram_wdata, io_wdata;
   logic [AW-2:0]     ram_addr;
   logic [IO_AW-1:0]  io_addr;

   mem_bus_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .IO_AW(IO_AW)) dut (
      .clk(clk), .reset_n(reset_n), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .wdata(wdata),
      .mem_ready(mem_ready), .rdata(rdata), .bus_err(bus_err),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
      .ram_rdata(ram_rdata), .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we),
      .io_re(io_re), .io_rdata(io_rdata)
   );

   int cyc = 0, n_checks = 0, n_fail = 0;

   // Expected schedule, indexed by cycle number.
   bit           exp_ready[MAXC], exp_err[MAXC], exp_ram_we[MAXC], exp_ram_re[MAXC];
   bit           exp_io_we[MAXC], exp_io_re[MAXC], rd_upd[MAXC];
   logic [15:0]  rd_val[MAXC], exp_data[MAXC];
   logic [8:0]   exp_addr[MAXC];
   logic [15:0]  model_rdata = 16'h0;
   logic [15:0]  model_mem[256];
   logic [15:0]  ram_dev[256];

   int           ready_count = 0, ram_we_count = 0, ram_re_count = 0;
   int           last_ready_cyc = 0, last_err_cyc = -1, cmp_c;
   logic [7:0]   last_ram_addr = 8'h0;
   logic [15:0]  last_ram_wdata = 16'h0;
   logic [3:0]   last_io_addr = 4'h0;

   typedef struct {int due; logic [7:0] a;} rd_req_t;
   rd_req_t rq[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // RAM device: data appears RD_LAT cycles after the ram_re cycle, garbage otherwise.
   always @(negedge clk) begin
      ram_rdata = 16'($urandom);
      if (!reset_n) begin
         rq.delete();
      end else begin
         if (rq.size() > 0 && rq[0].due == cyc) begin
            ram_rdata = ram_dev[rq[0].a];
            void'(rq.pop_front());
         end
         if (ram_re) rq.push_back('{cyc + RD_LAT, ram_addr});
         if (ram_we) ram_dev[ram_addr] = ram_wdata;
      end
   end

   // Per-cycle comparison against the scheduled expectations.
   always begin
      @(posedge clk);
      #1;
      cmp_c = cyc;
      if (cmp_c < MAXC) begin
         if (rd_upd[cmp_c]) model_rdata = rd_val[cmp_c];
         check_output("mem_ready", 32'(mem_ready), 32'(exp_ready[cmp_c]));
         check_output("bus_err",   32'(bus_err),   32'(exp_err[cmp_c]));
         check_output("ram_we",    32'(ram_we),    32'(exp_ram_we[cmp_c]));
         check_output("ram_re",    32'(ram_re),    32'(exp_ram_re[cmp_c]));
         check_output("io_we",     32'(io_we),     32'(exp_io_we[cmp_c]));
         check_output("io_re",     32'(io_re),     32'(exp_io_re[cmp_c]));
         check_output("rdata",     32'(rdata),     32'(model_rdata));
         if (exp_ram_we[cmp_c] || exp_ram_re[cmp_c])
            check_output("ram_addr", 32'(ram_addr), 32'(exp_addr[cmp_c][7:0]));
         if (exp_ram_we[cmp_c]) check_output("ram_wdata", 32'(ram_wdata), 32'(exp_data[cmp_c]));
         if (exp_io_we[cmp_c] || exp_io_re[cmp_c])
            check_output("io_addr", 32'(io_addr), 32'(exp_addr[cmp_c][3:0]));
         if (exp_io_we[cmp_c]) check_output("io_wdata", 32'(io_wdata), 32'(exp_data[cmp_c]));
      end
      if (mem_ready) begin ready_count++; last_ready_cyc = cmp_c; end
      if (bus_err) last_err_cyc = cmp_c;
      if (ram_we) begin ram_we_count++; last_ram_addr = ram_addr; last_ram_wdata = ram_wdata; end
      if (ram_re) ram_re_count++;
      if (io_we || io_re) last_io_addr = io_addr;
   end

   task automatic clear_schedule();
      for (int i = cyc; i < MAXC; i++) begin
         exp_ready[i] = 0; exp_err[i] = 0; exp_ram_we[i] = 0; exp_ram_re[i] = 0;
         exp_io_we[i] = 0; exp_io_re[i] = 0; rd_upd[i] = 0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_ready"}, 32'(mem_ready), 32'h0);
      check_output({tag, "_err"},   32'(bus_err),   32'h0);
      check_output({tag, "_strb"},  32'({ram_we, ram_re, io_we, io_re}), 32'h0);
      check_output({tag, "_rdata"}, 32'(rdata),     32'h0);
   endtask

   // Issues one command at the current negedge, records what the bus must do, and
   // returns at the negedge of the ready cycle (or after an injected reset).
   task automatic apply_stimulus(input logic [1:0] cmd, input logic [8:0] addr,
                                 input logic [15:0] data, input logic [15:0] ioval,
                                 input bit scramble, input int abort_after, output int k0);
      int r;
      k0 = cyc;
      mem_cmd = cmd; mem_addr = addr; wdata = data; io_rdata = ioval;
      r = k0 + 2;
      case (cmd)
         2'b01: begin
            exp_addr[k0+1] = addr; exp_data[k0+1] = data;
            if (addr[8]) exp_io_we[k0+1] = 1;
            else begin exp_ram_we[k0+1] = 1; model_mem[addr[7:0]] = data; end
         end
         2'b10: begin
            exp_addr[k0+1] = addr;
            if (addr[8]) begin
               exp_io_re[k0+1] = 1; rd_upd[r] = 1; rd_val[r] = ioval;
            end else begin
               exp_ram_re[k0+1] = 1; r = k0 + RD_LAT + 2;
               rd_upd[r] = 1; rd_val[r] = model_mem[addr[7:0]];
            end
         end
         default: exp_err[r] = 1;
      endcase
      exp_ready[r] = 1;
      while (cyc < r) begin
         @(negedge clk);
         if (abort_after > 0 && cyc == k0 + abort_after) begin
            reset_n = 1'b0; mem_cmd = 2'b00;
            clear_schedule();
            model_rdata = 16'h0;
            #1;
            check_all_zero("abort");
            repeat (2) @(negedge clk);
            check_all_zero("abort_hold");
            reset_n = 1'b1;
            return;
         end
         if (scramble && cyc < r) begin mem_addr = 9'($urandom); wdata = 16'($urandom); end
      end
   endtask

   task automatic idle_cycles(input int n);
      @(negedge clk);
      mem_cmd = 2'b00; io_rdata = 16'($urandom);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [8:0] pick_addr();
      case ($urandom_range(0, 5))
         0: return 9'h000;
         1: return 9'h1FF;
         2: return 9'h100 | 9'($urandom_range(0, 15));
         3: return 9'h0FF;
         default: return 9'($urandom_range(0, 15));
      endcase
   endfunction

   initial begin
      int k0, base_a, base_b, rc0, sel;
      logic [1:0] cmd;
      reset_n = 1'b1; mem_cmd = 2'b00; mem_addr = '0; wdata = '0; io_rdata = '0;
      for (int i = 0; i < 256; i++) begin
         model_mem[i] = 16'(i * 311 + 5);
         ram_dev[i]   = 16'(i * 311 + 5);
      end
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);

      base_a = ram_we_count;
      apply_stimulus(2'b01, 9'h005, 16'hBEEF, 16'h0, 0, 0, k0);
      check_output("wr_latency", 32'(last_ready_cyc - k0), 32'd2);
      check_output("wr_ram_addr", 32'(last_ram_addr), 32'h05);
      check_output("wr_ram_wdata", 32'(last_ram_wdata), 32'hBEEF);
      check_output("wr_we_pulses", 32'(ram_we_count - base_a), 32'd1);
      idle_cycles(1);

      base_a = ram_re_count;
      apply_stimulus(2'b10, 9'h005, 16'h0, 16'h0, 1, 0, k0);
      check_output("rd_latency", 32'(last_ready_cyc - k0), 32'd5);
      check_output("rd_rdata", 32'(rdata), 32'hBEEF);
      check_output("rd_re_pulses", 32'(ram_re_count - base_a), 32'd1);
      idle_cycles(1);

      base_b = ram_we_count + ram_re_count;
      apply_stimulus(2'b01, 9'h102, 16'h00AA, 16'h0, 0, 0, k0);
      idle_cycles(0);
      apply_stimulus(2'b10, 9'h102, 16'h0, 16'h1234, 0, 0, k0);
      check_output("io_addr", 32'(last_io_addr), 32'h2);
      check_output("io_rdata", 32'(rdata), 32'h1234);
      check_output("io_no_ram", 32'(ram_we_count + ram_re_count - base_b), 32'd0);
      idle_cycles(1);

      apply_stimulus(2'b11, 9'h005, 16'h7777, 16'h0, 0, 0, k0);
      check_output("ill_err_cycle", 32'(last_err_cyc - k0), 32'd2);
      check_output("ill_rdata_kept", 32'(rdata), 32'h1234);
      idle_cycles(1);

      rc0 = ready_count;
      apply_stimulus(2'b01, 9'h0A0, 16'h1357, 16'h0, 0, 0, k0);
      @(negedge clk);
      apply_stimulus(2'b01, 9'h0A0, 16'h1357, 16'h0, 0, 0, k0);
      check_output("b2b_readys", 32'(ready_count - rc0), 32'd2);
      idle_cycles(2);
      apply_stimulus(2'b10, 9'h0A0, 16'h0, 16'h0, 1, 0, k0);
      check_output("b2b_rdata", 32'(rdata), 32'h1357);
      idle_cycles(0);

      apply_stimulus(2'b01, 9'h000, 16'hA5A5, 16'h0, 1, 0, k0);
      idle_cycles(0);
      apply_stimulus(2'b01, 9'h1FF, 16'h5A5A, 16'h0, 1, 0, k0);
      check_output("bnd_io_addr", 32'(last_io_addr), 32'hF);
      idle_cycles(0);
      apply_stimulus(2'b10, 9'h000, 16'h0, 16'h0, 1, 0, k0);
      check_output("bnd_ram0", 32'(rdata), 32'hA5A5);
      idle_cycles(0);
      apply_stimulus(2'b10, 9'h1FF, 16'h0, 16'h0F0F, 1, 0, k0);
      check_output("bnd_io_ff", 32'(rdata), 32'h0F0F);
      idle_cycles(1);

      apply_stimulus(2'b10, 9'h005, 16'h0, 16'h0, 0, 2, k0);
      idle_cycles(1);
      apply_stimulus(2'b10, 9'h005, 16'h0, 16'h0, 1, 0, k0);
      check_output("post_reset_rd", 32'(rdata), 32'hBEEF);

      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 19);
         cmd = (sel < 9) ? 2'b01 : (sel < 18) ? 2'b10 : 2'b11;
         if ($urandom_range(0, 9) < 3) @(negedge clk);
         else idle_cycles($urandom_range(0, 2));
         apply_stimulus(cmd, pick_addr(), 16'($urandom), 16'($urandom), 1, 0, k0);
      end
      idle_cycles(3);

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
